// File: rtl/div_if.sv
// Request/response bundle between the EX stage and the multi-cycle divider.
// The EX stage is the master; the divider is the slave.
interface div_if #(
  parameter int WIDTH = 32
);
  logic               signed_div;
  logic [WIDTH-1:0]   opdata1;
  logic [WIDTH-1:0]   opdata2;
  logic               start;
  logic               annul;
  logic [2*WIDTH-1:0] result;
  logic               ready;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready
  );
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// result word is {remainder, quotient} for the HI/LO write.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

  state_t               state, state_n;
  logic [WIDTH-1:0]     rem, rem_n;
  logic [WIDTH-1:0]     dvd, dvd_n;
  logic [WIDTH-1:0]     dsr, dsr_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic                 q_neg, q_neg_n;
  logic                 r_neg, r_neg_n;
  logic [2*WIDTH-1:0]   res, res_n;
  logic                 rdy, rdy_n;

  logic [WIDTH:0]       shifted;
  logic [WIDTH:0]       trial;
  logic                 qbit;
  logic [WIDTH-1:0]     rem_step;
  logic [WIDTH-1:0]     quo_step;
  logic                 a_neg;
  logic                 b_neg;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;

  // Magnitudes are only taken in signed mode; 0x80000000 maps to itself,
  // which is the correct unsigned magnitude.
  assign a_neg = bus.signed_div & bus.opdata1[WIDTH-1];
  assign b_neg = bus.signed_div & bus.opdata2[WIDTH-1];
  assign abs_a = a_neg ? -bus.opdata1 : bus.opdata1;
  assign abs_b = b_neg ? -bus.opdata2 : bus.opdata2;

  // The partial remainder is always below the divisor, so the shifted value
  // fits in WIDTH+1 bits and the trial sign bit decides the quotient bit.
  assign shifted  = {rem, dvd[WIDTH-1]};
  assign trial    = shifted - {1'b0, dsr};
  assign qbit     = ~trial[WIDTH];
  assign rem_step = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_step = {dvd[WIDTH-2:0], qbit};

  // NOTE: every combinational output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_n = state;
    rem_n   = rem;
    dvd_n   = dvd;
    dsr_n   = dsr;
    cnt_n   = cnt;
    q_neg_n = q_neg;
    r_neg_n = r_neg;
    res_n   = res;
    rdy_n   = rdy;

    unique case (state)
      IDLE: begin
        res_n = '0;
        rdy_n = 1'b0;
        if (bus.start && !bus.annul) begin
          if (bus.opdata2 == '0) begin
            state_n = DIVZERO;
          end else begin
            state_n = BUSY;
            cnt_n   = '0;
            rem_n   = '0;
            dvd_n   = abs_a;
            dsr_n   = abs_b;
            q_neg_n = a_neg ^ b_neg;
            r_neg_n = a_neg;
          end
        end
      end

      DIVZERO: begin
        res_n = '0;
        if (bus.annul) begin
          state_n = IDLE;
          rdy_n   = 1'b0;
        end else begin
          state_n = DONE;
          rdy_n   = 1'b1;
        end
      end

      BUSY: begin
        // Annul wins over completion on the same edge.
        if (bus.annul) begin
          state_n = IDLE;
          res_n   = '0;
          rdy_n   = 1'b0;
        end else begin
          rem_n = rem_step;
          dvd_n = quo_step;
          cnt_n = cnt + 1'b1;
          if (cnt == LAST) begin
            state_n = DONE;
            cnt_n   = '0;
            rdy_n   = 1'b1;
            res_n   = {r_neg ? -rem_step : rem_step,
                       q_neg ? -quo_step : quo_step};
          end
        end
      end

      DONE: begin
        if (!bus.start || bus.annul) begin
          state_n = IDLE;
          res_n   = '0;
          rdy_n   = 1'b0;
        end
      end

      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      dvd   <= '0;
      dsr   <= '0;
      cnt   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      res   <= '0;
      rdy   <= 1'b0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      dvd   <= dvd_n;
      dsr   <= dsr_n;
      cnt   <= cnt_n;
      q_neg <= q_neg_n;
      r_neg <= r_neg_n;
      res   <= res_n;
      rdy   <= rdy_n;
    end
  end

  assign bus.result = res;
  assign bus.ready  = rdy;
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned results, divide by
// zero, annul, mid-operation reset and operand stability.
module tb_div_unit;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;

  div_if #(.WIDTH(32)) bus ();

  div_unit #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation, let it be accepted, and count edges until ready.
  // mut_at/drop_at (-1 = never) perturb operands or drop start mid-BUSY.
  task automatic do_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                        input int mut_at, input int drop_at,
                        output int lat, output logic [63:0] res);
    bus.signed_div = sd;
    bus.opdata1    = a;
    bus.opdata2    = b;
    bus.annul      = 1'b0;
    bus.start      = 1'b1;
    tick();
    lat = 0;
    while (!bus.ready && lat < 100) begin
      if (lat == mut_at) begin
        bus.opdata1    = 32'h1234_5678;
        bus.opdata2    = 32'h0000_0003;
        bus.signed_div = ~sd;
      end
      if (lat == drop_at) bus.start = 1'b0;
      tick();
      lat++;
    end
    res = bus.result;
  endtask

  // One more edge with start held, then drop start for the return to IDLE.
  task automatic finish_op(output logic hold_rdy, output logic [63:0] hold_res,
                           output logic rel_rdy, output logic [63:0] rel_res);
    tick();
    hold_rdy = bus.ready;
    hold_res = bus.result;
    bus.start = 1'b0;
    tick();
    rel_rdy = bus.ready;
    rel_res = bus.result;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.annul = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1 = '0;
    bus.opdata2 = '0;
    tick();
    tick();
    checks++;
    if (bus.ready !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.ready);
    else passed++;
    checks++;
    if (bus.result !== 64'h0) $display("FAIL reset_result: got %h want 0", bus.result);
    else passed++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_divide(input string name, input logic sd, input logic [31:0] a,
                             input logic [31:0] b, input int exp_lat,
                             input logic [63:0] exp_res);
    int lat;
    logic [63:0] res, hres, rres;
    logic hrdy, rrdy;
    do_div(sd, a, b, -1, -1, lat, res);
    checks++;
    if (lat !== exp_lat) $display("FAIL %s_latency: got %0d want %0d", name, lat, exp_lat);
    else passed++;
    checks++;
    if (res !== exp_res) $display("FAIL %s_result: got %h want %h", name, res, exp_res);
    else passed++;
    finish_op(hrdy, hres, rrdy, rres);
    checks++;
    if (hrdy !== 1'b1 || hres !== exp_res)
      $display("FAIL %s_hold: got rdy=%b res=%h want rdy=1 res=%h", name, hrdy, hres, exp_res);
    else passed++;
    checks++;
    if (rrdy !== 1'b0 || rres !== 64'h0)
      $display("FAIL %s_release: got rdy=%b res=%h want rdy=0 res=0", name, rrdy, rres);
    else passed++;
  endtask

  task automatic test_annul();
    int lat;
    int early = 0;
    logic [63:0] res, hres, rres;
    logic hrdy, rrdy;
    bus.signed_div = 1'b0;
    bus.opdata1 = 32'd100;
    bus.opdata2 = 32'd7;
    bus.start = 1'b1;
    tick();
    for (int i = 1; i < 10; i++) begin
      tick();
      if (bus.ready) early++;
    end
    bus.annul = 1'b1;
    tick();
    checks++;
    if (bus.ready !== 1'b0 || bus.result !== 64'h0 || early != 0)
      $display("FAIL annul_abort: got rdy=%b res=%h early=%0d want rdy=0 res=0 early=0",
               bus.ready, bus.result, early);
    else passed++;
    bus.annul = 1'b0;
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.ready !== 1'b0) $display("FAIL annul_idle: got rdy=%b want 0", bus.ready);
    else passed++;
    do_div(1'b0, 32'd9, 32'd3, -1, -1, lat, res);
    checks++;
    if (lat !== 32 || res !== 64'h0000_0000_0000_0003)
      $display("FAIL annul_followup: got lat=%0d res=%h want lat=32 res=%h",
               lat, res, 64'h0000_0000_0000_0003);
    else passed++;
    finish_op(hrdy, hres, rrdy, rres);
  endtask

  task automatic test_busy_reset();
    int lat;
    logic [63:0] res, hres, rres;
    logic hrdy, rrdy;
    bus.signed_div = 1'b1;
    bus.opdata1 = 32'hFFFF_FFF9;
    bus.opdata2 = 32'd2;
    bus.start = 1'b1;
    tick();
    for (int i = 1; i < 20; i++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (bus.ready !== 1'b0 || bus.result !== 64'h0)
      $display("FAIL busy_reset: got rdy=%b res=%h want rdy=0 res=0", bus.ready, bus.result);
    else passed++;
    rst = 1'b0;
    do_div(1'b0, 32'd100, 32'd7, -1, -1, lat, res);
    checks++;
    if (lat !== 32 || res !== 64'h0000_0002_0000_000E)
      $display("FAIL reset_restart: got lat=%0d res=%h want lat=32 res=%h",
               lat, res, 64'h0000_0002_0000_000E);
    else passed++;
    finish_op(hrdy, hres, rrdy, rres);
  endtask

  task automatic test_operand_stability();
    int lat;
    logic [63:0] res, hres, rres;
    logic hrdy, rrdy;
    do_div(1'b0, 32'd100, 32'd7, 5, -1, lat, res);
    checks++;
    if (lat !== 32 || res !== 64'h0000_0002_0000_000E)
      $display("FAIL stable_operands: got lat=%0d res=%h want lat=32 res=%h",
               lat, res, 64'h0000_0002_0000_000E);
    else passed++;
    finish_op(hrdy, hres, rrdy, rres);
  endtask

  task automatic test_start_drop();
    int lat;
    logic [63:0] res;
    do_div(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD, -1, 12, lat, res);
    checks++;
    if (lat !== 32 || res !== 64'hFFFF_FFFE_0000_0002)
      $display("FAIL start_drop_complete: got lat=%0d res=%h want lat=32 res=%h",
               lat, res, 64'hFFFF_FFFE_0000_0002);
    else passed++;
    tick();
    checks++;
    if (bus.ready !== 1'b0 || bus.result !== 64'h0)
      $display("FAIL start_drop_idle: got rdy=%b res=%h want rdy=0 res=0", bus.ready, bus.result);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_divide("divu_100_7",     1'b0, 32'd100,       32'd7,         32, 64'h0000_0002_0000_000E);
    test_divide("div_m7_2",       1'b1, 32'hFFFF_FFF9, 32'd2,         32, 64'hFFFF_FFFF_FFFF_FFFD);
    test_divide("div_7_m2",       1'b1, 32'd7,         32'hFFFF_FFFE, 32, 64'h0000_0001_FFFF_FFFD);
    test_divide("div_by_zero",    1'b1, 32'd5,         32'd0,         1,  64'h0);
    test_divide("div_overflow",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32, 64'h0000_0000_8000_0000);
    test_divide("divu_max_1",     1'b0, 32'hFFFF_FFFF, 32'd1,         32, 64'h0000_0000_FFFF_FFFF);
    test_divide("divu_8000_ffff", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32, 64'h8000_0000_0000_0000);
    test_annul();
    test_busy_reset();
    test_operand_stability();
    test_start_drop();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
